// File: rtl/i2c_relay_tamper_ctrl.sv
// i2c_relay_tamper_ctrl: relays slave-side I2C bytes to one I2C master behind a virtual pointer map
// Ports: ICE_CLK/RST_N clock and async active-low reset; SLV_* slave byte interface plus SCL stretch;
// M_* one-outstanding master command/response handshake; TRIG tamper arm; BUSY/ERR/TAMPER_CNT status.
// Define I2C_RELAY_TAMPER_EN to XOR reads at TAMPER_PTR with TAMPER_MASK while TRIG is high.
module i2c_relay_tamper_ctrl #(
  parameter int NUM_CH = 4,
  parameter logic [7*NUM_CH-1:0] PERIPH_ADDRS = {NUM_CH{7'h19}},
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
  parameter logic [7:0] TAMPER_PTR = 8'h29,
  parameter logic [7:0] TAMPER_MASK = 8'hFF
) (
  input  logic       ICE_CLK,
  input  logic       RST_N,
  input  logic       SLV_START,
  input  logic       SLV_RW,
  input  logic       SLV_WR_VALID,
  input  logic [7:0] SLV_WR_DATA,
  input  logic       SLV_RD_REQ,
  output logic [7:0] SLV_RD_DATA,
  output logic       SLV_RD_VALID,
  input  logic       SLV_STOP,
  output logic       SLV_STRETCH,
  output logic       M_CMD_VALID,
  input  logic       M_CMD_READY,
  output logic [2:0] M_CMD,
  output logic [7:0] M_CMD_DATA,
  input  logic       M_RSP_VALID,
  input  logic [7:0] M_RSP_DATA,
  input  logic       M_RSP_NACK,
  input  logic       TRIG,
  output logic       BUSY,
  output logic       ERR,
  output logic [7:0] TAMPER_CNT
);
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam logic [7:0] REG_MSK = 8'hFF >> CH_W;
  localparam logic [2:0] C_START_W = 3'd0, C_START_R = 3'd1, C_WRITE = 3'd2, C_READ_NACK = 3'd3, C_STOP = 3'd4;
  typedef enum logic [2:0] {IDLE, PTR, WR_SEQ, RD_SEQ, PRESENT, ABORT} state_t;
  state_t state_q, state_d;
  logic [7:0] ptr_q, ptr_d, wr_data_q, wr_data_d, rd_data_q, rd_data_d, cnt_q, cnt_d;
  logic [2:0] step_q, step_d, cmd;
  logic [15:0] tmo_q, tmo_d;
  logic pend_q, pend_d, rd_wait_q, rd_wait_d, loaded_q, loaded_d;
  logic discard_q, discard_d, is_rd_q, is_rd_d, err_q, err_d;
  logic [6:0] addr;
  logic [7:0] ptr_inc, reg_byte, cmd_data;
  logic last, tamper, fault, in_seq;
  // Channel bits select the peripheral; the register field wraps without carrying into them.
  always_comb begin
    addr = PERIPH_ADDRS[6:0];
    for (int i = 0; i < NUM_CH; i++)
      if (ptr_q[7 -: CH_W] == CH_W'(i)) addr = PERIPH_ADDRS[7*i +: 7];
  end
  assign reg_byte = ptr_q & REG_MSK;
  assign ptr_inc = (ptr_q & ~REG_MSK) | ((ptr_q + 8'd1) & REG_MSK);
  assign last = step_q == (is_rd_q ? 3'd4 : 3'd3);
  assign in_seq = state_q == WR_SEQ || state_q == RD_SEQ;
`ifdef I2C_RELAY_TAMPER_EN
  assign tamper = TRIG && ptr_q == TAMPER_PTR;
`else
  logic unused_tamper;
  assign tamper = 1'b0;
  assign unused_tamper = ^{TRIG, TAMPER_PTR};
`endif
  always_comb begin
    cmd = C_STOP;
    cmd_data = 8'h00;
    if (in_seq)
      case (step_q)
        3'd0: begin cmd = C_START_W; cmd_data = {addr, 1'b0}; end
        3'd1: begin cmd = C_WRITE; cmd_data = reg_byte; end
        3'd2: begin cmd = is_rd_q ? C_START_R : C_WRITE; cmd_data = is_rd_q ? {addr, 1'b1} : wr_data_q; end
        3'd3: cmd = is_rd_q ? C_READ_NACK : C_STOP;
        default: cmd = C_STOP;
      endcase
  end
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    wr_data_d = wr_data_q;
    rd_data_d = rd_data_q;
    cnt_d = cnt_q;
    step_d = step_q;
    pend_d = pend_q;
    rd_wait_d = rd_wait_q;
    loaded_d = loaded_q;
    discard_d = discard_q;
    is_rd_d = is_rd_q;
    err_d = err_q;
    fault = 1'b0;
    tmo_d = (in_seq || state_q == ABORT) ? tmo_q + 16'd1 : 16'd0;
    case (state_q)
      IDLE:
        if (SLV_START && !SLV_RW) begin
          state_d = PTR;
          loaded_d = 1'b0;
          rd_wait_d = 1'b0;
        end else if (SLV_START) rd_wait_d = 1'b1;
        else if (SLV_STOP) rd_wait_d = 1'b0;
        else if (SLV_RD_REQ && rd_wait_q) begin
          state_d = RD_SEQ;
          is_rd_d = 1'b1;
          discard_d = 1'b0;
          step_d = 3'd0;
          pend_d = 1'b1;
          tmo_d = 16'd0;
          rd_wait_d = 1'b0;
        end
      PTR:
        if (SLV_STOP) state_d = IDLE;
        else if (SLV_WR_VALID && !loaded_q) begin
          ptr_d = SLV_WR_DATA;
          loaded_d = 1'b1;
        end else if (SLV_WR_VALID) begin
          state_d = WR_SEQ;
          wr_data_d = SLV_WR_DATA;
          is_rd_d = 1'b0;
          discard_d = 1'b0;
          step_d = 3'd0;
          pend_d = 1'b1;
          tmo_d = 16'd0;
        end
      WR_SEQ, RD_SEQ: begin
        // A STOP mid-sequence lets the sequence finish but drops its result.
        discard_d = discard_q | SLV_STOP;
        if (pend_q && M_CMD_READY) pend_d = 1'b0;
        else if (!pend_q && M_RSP_VALID && M_RSP_NACK) fault = 1'b1;
        else if (!pend_q && M_RSP_VALID) begin
          tmo_d = 16'd0;
          if (is_rd_q && step_q == 3'd3) begin
            rd_data_d = M_RSP_DATA ^ (tamper ? TAMPER_MASK : 8'h00);
            cnt_d = (tamper && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
          end
          if (last) begin
            ptr_d = is_rd_q ? ptr_q : ptr_inc;
            state_d = discard_d ? IDLE : is_rd_q ? PRESENT : PTR;
          end else begin
            step_d = step_q + 3'd1;
            pend_d = 1'b1;
          end
        end else if (tmo_q >= TIMEOUT_CYCLES) fault = 1'b1;
      end
      ABORT: begin
        discard_d = discard_q | SLV_STOP;
        if (pend_q && M_CMD_READY) pend_d = 1'b0;
        else if ((!pend_q && M_RSP_VALID) || tmo_q >= TIMEOUT_CYCLES) begin
          pend_d = 1'b0;
          rd_data_d = 8'hFF;
          state_d = (is_rd_q && !discard_d) ? PRESENT : IDLE;
        end
      end
      PRESENT: begin
        state_d = IDLE;
        ptr_d = ptr_inc;
        rd_wait_d = !SLV_STOP;
      end
      default: state_d = IDLE;
    endcase
    if (fault) begin
      state_d = ABORT;
      pend_d = 1'b1;
      tmo_d = 16'd0;
      err_d = 1'b1;
    end
  end
  always_ff @(posedge ICE_CLK or negedge RST_N)
    if (!RST_N) begin
      state_q <= IDLE;
      ptr_q <= 8'h00;
      wr_data_q <= 8'h00;
      rd_data_q <= 8'h00;
      cnt_q <= 8'h00;
      step_q <= 3'd0;
      tmo_q <= 16'd0;
      pend_q <= 1'b0;
      rd_wait_q <= 1'b0;
      loaded_q <= 1'b0;
      discard_q <= 1'b0;
      is_rd_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      wr_data_q <= wr_data_d;
      rd_data_q <= rd_data_d;
      cnt_q <= cnt_d;
      step_q <= step_d;
      tmo_q <= tmo_d;
      pend_q <= pend_d;
      rd_wait_q <= rd_wait_d;
      loaded_q <= loaded_d;
      discard_q <= discard_d;
      is_rd_q <= is_rd_d;
      err_q <= err_d;
    end
  assign M_CMD_VALID = pend_q;
  assign M_CMD = pend_q ? cmd : 3'd0;
  assign M_CMD_DATA = pend_q ? cmd_data : 8'h00;
  assign SLV_RD_VALID = state_q == PRESENT;
  assign SLV_RD_DATA = SLV_RD_VALID ? rd_data_q : 8'h00;
  assign SLV_STRETCH = in_seq || state_q == ABORT;
  assign BUSY = state_q != IDLE;
  assign ERR = err_q;
  assign TAMPER_CNT = cnt_q;
endmodule

// File: tb/tb_i2c_relay_tamper_ctrl.sv
// tb_i2c_relay_tamper_ctrl: vector table plus corner-case sequences against a simple I2C master model
module tb_i2c_relay_tamper_ctrl;
`ifdef I2C_RELAY_TAMPER_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif
  typedef struct {
    bit rd;
    bit trg;
    logic [7:0] ptr;
    logic [7:0] dat;
    logic [7:0] exp;
    logic [7:0] cnt;
    logic [7:0] st;
    logic [7:0] rg;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic slv_start = 1'b0, slv_rw = 1'b0, slv_wr_valid = 1'b0, slv_rd_req = 1'b0, slv_stop = 1'b0, trig = 1'b0;
  logic [7:0] slv_wr_data = 8'h00;
  logic m_cmd_ready = 1'b0, m_rsp_valid = 1'b0, m_rsp_nack = 1'b0;
  logic [7:0] m_rsp_data = 8'h00;
  logic [7:0] slv_rd_data, m_cmd_data, tamper_cnt;
  logic slv_rd_valid, slv_stretch, m_cmd_valid, busy, err;
  logic [2:0] m_cmd;
  logic [10:0] log_q[$];
  int nack_at = -1;
  bit ready_en = 1'b1;
  logic [7:0] rsp_byte = 8'h00;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  i2c_relay_tamper_ctrl #(
    .NUM_CH(4),
    .PERIPH_ADDRS({7'h1C, 7'h1B, 7'h1A, 7'h19}),
    .TIMEOUT_CYCLES(16'd30)
  ) dut (
    .ICE_CLK(clk), .RST_N(rst_n),
    .SLV_START(slv_start), .SLV_RW(slv_rw), .SLV_WR_VALID(slv_wr_valid), .SLV_WR_DATA(slv_wr_data),
    .SLV_RD_REQ(slv_rd_req), .SLV_RD_DATA(slv_rd_data), .SLV_RD_VALID(slv_rd_valid), .SLV_STOP(slv_stop),
    .SLV_STRETCH(slv_stretch), .M_CMD_VALID(m_cmd_valid), .M_CMD_READY(m_cmd_ready), .M_CMD(m_cmd),
    .M_CMD_DATA(m_cmd_data), .M_RSP_VALID(m_rsp_valid), .M_RSP_DATA(m_rsp_data), .M_RSP_NACK(m_rsp_nack),
    .TRIG(trig), .BUSY(busy), .ERR(err), .TAMPER_CNT(tamper_cnt)
  );
  // Master model: logs each command, accepts it, answers two cycles later.
  initial forever begin
    @(negedge clk);
    if (rst_n && m_cmd_valid && ready_en) begin
      log_q.push_back({m_cmd, m_cmd_data});
      m_cmd_ready = 1'b1;
      @(negedge clk);
      m_cmd_ready = 1'b0;
      repeat (2) @(negedge clk);
      m_rsp_valid = 1'b1;
      m_rsp_nack = (log_q.size() - 1) == nack_at;
      m_rsp_data = rsp_byte;
      @(negedge clk);
      m_rsp_valid = 1'b0;
      m_rsp_nack = 1'b0;
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic logic [10:0] ent(input int i);
    return (i < log_q.size()) ? log_q[i] : 11'h7FF;
  endfunction
  task automatic do_start(input bit rw);
    @(negedge clk);
    slv_start = 1'b1;
    slv_rw = rw;
    @(negedge clk);
    slv_start = 1'b0;
  endtask
  task automatic do_stop();
    @(negedge clk);
    slv_stop = 1'b1;
    @(negedge clk);
    slv_stop = 1'b0;
  endtask
  task automatic do_byte(input logic [7:0] b);
    @(negedge clk);
    slv_wr_valid = 1'b1;
    slv_wr_data = b;
    @(negedge clk);
    slv_wr_valid = 1'b0;
  endtask
  task automatic wait_unstretched(input string nm);
    int n = 0;
    while (slv_stretch && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(nm, slv_stretch, 0);
  endtask
  task automatic wr_tx(input logic [7:0] p, input logic [7:0] d0, input logic [7:0] d1, input int nd);
    do_start(1'b0);
    do_byte(p);
    if (nd > 0) begin
      do_byte(d0);
      wait_unstretched("wr_relay0_done");
    end
    if (nd > 1) begin
      do_byte(d1);
      wait_unstretched("wr_relay1_done");
    end
    do_stop();
  endtask
  task automatic rd_next(output logic [7:0] got);
    int n = 0;
    bit held = 1'b1;
    @(negedge clk);
    slv_rd_req = 1'b1;
    @(negedge clk);
    slv_rd_req = 1'b0;
    while (!slv_rd_valid && n < 500) begin
      held &= slv_stretch;
      @(negedge clk);
      n++;
    end
    chk("rd_stretch_held", held, 1);
    chk("rd_valid_seen", slv_rd_valid, 1);
    chk("rd_stretch_drop", slv_stretch, 0);
    got = slv_rd_data;
  endtask
  task automatic rd_tx(input logic [7:0] p, output logic [7:0] got);
    wr_tx(p, 8'h00, 8'h00, 0);
    do_start(1'b1);
    rd_next(got);
  endtask
  vec_t v[7];
  logic [7:0] got;
  int n;
  initial begin
    v[0] = '{1'b0, 1'b0, 8'h20, 8'h57, 8'h00, 8'd0, 8'h32, 8'h20};
    v[1] = '{1'b0, 1'b0, 8'h45, 8'h11, 8'h00, 8'd0, 8'h34, 8'h05};
    v[2] = '{1'b0, 1'b0, 8'hC3, 8'hEE, 8'h00, 8'd0, 8'h38, 8'h03};
    v[3] = '{1'b1, 1'b0, 8'h28, 8'hA5, 8'hA5, 8'd0, 8'h32, 8'h28};
    v[4] = '{1'b1, 1'b1, 8'h29, 8'h3C, TEN ? 8'hC3 : 8'h3C, TEN ? 8'd1 : 8'd0, 8'h32, 8'h29};
    v[5] = '{1'b1, 1'b0, 8'h29, 8'h3C, 8'h3C, TEN ? 8'd1 : 8'd0, 8'h32, 8'h29};
    v[6] = '{1'b1, 1'b1, 8'h8A, 8'h5A, 8'h5A, TEN ? 8'd1 : 8'd0, 8'h36, 8'h0A};
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_stretch", slv_stretch, 0);
    chk("rst_cmd_valid", m_cmd_valid, 0);
    chk("rst_rd_valid", slv_rd_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_tcnt", tamper_cnt, 0);
    rst_n = 1'b1;
    // reset pointer is 8'h00: a read without loading it addresses channel 0 register 0
    rsp_byte = 8'h66;
    do_start(1'b1);
    rd_next(got);
    do_stop();
    chk("rst_ptr_data", got, 8'h66);
    chk("rst_ptr_start", ent(0), {3'd0, 8'h32});
    chk("rst_ptr_reg", ent(1), {3'd2, 8'h00});
    for (int i = 0; i < 7; i++) begin
      trig = v[i].trg;
      rsp_byte = v[i].dat;
      log_q.delete();
      if (v[i].rd) begin
        rd_tx(v[i].ptr, got);
        do_stop();
        chk($sformatf("v%0d_rd_data", i), got, v[i].exp);
        chk($sformatf("v%0d_rd_ncmd", i), log_q.size(), 5);
        chk($sformatf("v%0d_rd_start_w", i), ent(0), {3'd0, v[i].st});
        chk($sformatf("v%0d_rd_reg", i), ent(1), {3'd2, v[i].rg});
        chk($sformatf("v%0d_rd_start_r", i), ent(2), {3'd1, v[i].st | 8'h01});
        chk($sformatf("v%0d_rd_read_nack", i), ent(3) >> 8, 3);
        chk($sformatf("v%0d_rd_stop", i), ent(4) >> 8, 4);
      end else begin
        wr_tx(v[i].ptr, v[i].dat, 8'h00, 1);
        chk($sformatf("v%0d_wr_ncmd", i), log_q.size(), 4);
        chk($sformatf("v%0d_wr_start_w", i), ent(0), {3'd0, v[i].st});
        chk($sformatf("v%0d_wr_reg", i), ent(1), {3'd2, v[i].rg});
        chk($sformatf("v%0d_wr_data", i), ent(2), {3'd2, v[i].dat});
        chk($sformatf("v%0d_wr_stop", i), ent(3) >> 8, 4);
      end
      chk($sformatf("v%0d_tcnt", i), tamper_cnt, v[i].cnt);
      chk($sformatf("v%0d_err", i), err, 0);
      chk($sformatf("v%0d_idle", i), busy, 0);
    end
    trig = 1'b0;
    // write pointer increments and wraps inside the register field
    log_q.delete();
    wr_tx(8'h20, 8'h57, 8'h58, 2);
    chk("inc_21_reg", ent(5), {3'd2, 8'h21});
    chk("inc_21_data", ent(6), {3'd2, 8'h58});
    log_q.delete();
    wr_tx(8'h3F, 8'h01, 8'h02, 2);
    chk("wrap_3f_start", ent(4), {3'd0, 8'h32});
    chk("wrap_3f_reg", ent(5), {3'd2, 8'h00});
    log_q.delete();
    wr_tx(8'h7F, 8'h01, 8'h02, 2);
    chk("wrap_7f_start", ent(4), {3'd0, 8'h34});
    chk("wrap_7f_reg", ent(5), {3'd2, 8'h00});
    // consecutive reads advance the pointer
    rsp_byte = 8'hA5;
    rd_tx(8'h28, got);
    chk("rdinc_first", got, 8'hA5);
    log_q.delete();
    rsp_byte = 8'h77;
    rd_next(got);
    do_stop();
    chk("rdinc_second", got, 8'h77);
    chk("rdinc_reg", ent(1), {3'd2, 8'h29});
    // reset in the middle of a read sequence
    wr_tx(8'h10, 8'h00, 8'h00, 0);
    do_start(1'b1);
    log_q.delete();
    @(negedge clk);
    slv_rd_req = 1'b1;
    @(negedge clk);
    slv_rd_req = 1'b0;
    n = 0;
    while (log_q.size() < 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("midrd_busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrd_rst_busy", busy, 0);
    chk("midrd_rst_stretch", slv_stretch, 0);
    chk("midrd_rst_cmd_valid", m_cmd_valid, 0);
    chk("midrd_rst_cmd", {m_cmd, m_cmd_data}, 0);
    chk("midrd_rst_rd_valid", {slv_rd_valid, slv_rd_data}, 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    // peripheral NACK on START_W during a read
    log_q.delete();
    nack_at = 0;
    rsp_byte = 8'hA5;
    rd_tx(8'h28, got);
    nack_at = -1;
    do_stop();
    chk("nack_rd_data", got, 8'hFF);
    chk("nack_ncmd", log_q.size(), 2);
    chk("nack_first_start", ent(0) >> 8, 0);
    chk("nack_stop", ent(1) >> 8, 4);
    chk("nack_err", err, 1);
    log_q.delete();
    wr_tx(8'h20, 8'h57, 8'h00, 1);
    chk("nack_after_ncmd", log_q.size(), 4);
    chk("nack_err_sticky", err, 1);
    // master never accepts: timeout, abort, back to idle
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("tmo_err_cleared", err, 0);
    ready_en = 1'b0;
    log_q.delete();
    do_start(1'b0);
    do_byte(8'h20);
    do_byte(8'h57);
    n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_idle", busy, 0);
    chk("tmo_err", err, 1);
    chk("tmo_not_early", n >= 30, 1);
    chk("tmo_no_accept", log_q.size(), 0);
    ready_en = 1'b1;
    do_stop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
